// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use/branch stalls, redirect flush, forwarding selects, multi-cycle MDU tracking.
// Define HAZARD_PERF_EN to add the stallCycles/flushCount performance counter ports.
module hazard_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int REG_BITS    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] rsD,
    input  logic [REG_BITS-1:0] rtD,
    input  logic [REG_BITS-1:0] rsE,
    input  logic [REG_BITS-1:0] rtE,
    input  logic [REG_BITS-1:0] writeRegE,
    input  logic [REG_BITS-1:0] writeRegM,
    input  logic [REG_BITS-1:0] writeRegW,
    input  logic                regWriteE,
    input  logic                regWriteM,
    input  logic                regWriteW,
    input  logic                memToRegE,
    input  logic                memToRegM,
    input  logic                branchD,
    input  logic                pcSrcD,
    input  logic                mduStartE,
    output logic                stallF,
    output logic                stallD,
    output logic                stallE,
    output logic                flushD,
    output logic                flushE,
    output logic                flushM,
    output logic [1:0]          forwardAE,
    output logic [1:0]          forwardBE,
    output logic                forwardAD,
    output logic                forwardBD,
    output logic                mduBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         stallCycles,
    output logic [31:0]         flushCount
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // BUSY covers cnt = LATENCY-2 .. 1; with the IDLE launch cycle that gives LATENCY-1 stalls.
    localparam logic [3:0] CNT_LOAD = 4'((MDU_LATENCY > 2) ? (MDU_LATENCY - 2) : 0);
    localparam logic       MDU_MULTI = (MDU_LATENCY > 1);
    localparam logic       MDU_BUSY  = (MDU_LATENCY > 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic lwstall, brstall, mdustall, stall_any;

    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src);
        if (regWriteM && (writeRegM != '0) && (writeRegM == src))
            return 2'b10;
        else if (regWriteW && (writeRegW != '0) && (writeRegW == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        forwardAE = fwd_sel(rsE);
        forwardBE = fwd_sel(rtE);
        forwardAD = regWriteM && (writeRegM != '0) && (writeRegM == rsD);
        forwardBD = regWriteM && (writeRegM != '0) && (writeRegM == rtD);
    end

    always_comb begin
        lwstall  = memToRegE && ((rtE == rsD) || (rtE == rtD));
        brstall  = branchD &&
                   ((regWriteE && ((writeRegE == rsD) || (writeRegE == rtD))) ||
                    (memToRegM && ((writeRegM == rsD) || (writeRegM == rtD))));
        mdustall = (state_q == BUSY) || ((state_q == IDLE) && mduStartE && MDU_MULTI);
        stall_any = lwstall | brstall | mdustall;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mduStartE && MDU_MULTI) begin
                    // LATENCY==2 needs only the launch-cycle stall, so skip BUSY.
                    state_d = MDU_BUSY ? BUSY : DONE;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates the controls combinationally so they drop the instant rst falls.
    always_comb begin
        stallF  = rst & stall_any;
        stallD  = rst & stall_any;
        stallE  = rst & mdustall;
        flushE  = rst & (lwstall | brstall) & ~mdustall;
        flushM  = rst & mdustall;
        flushD  = rst & pcSrcD & ~stall_any;
        mduBusy = rst & (state_q == BUSY);
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stallF};
        flush_cnt_d = flush_cnt_q + {31'd0, (flushD | flushE)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver queues hand-computed expectations, negedge monitor compares.
module tb_hazard_unit;

    logic       clk, rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       branchD, pcSrcD, mduStartE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, mduBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCycles, flushCount;
`endif

    hazard_unit #(.MDU_LATENCY(4), .REG_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .pcSrcD(pcSrcD), .mduStartE(mduStartE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD), .mduBusy(mduBusy)
`ifdef HAZARD_PERF_EN
        , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [12:0] exp;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    // {stallF, stallD, stallE, flushD, flushE, flushM, forwardAE, forwardBE, forwardAD, forwardBD, mduBusy}
    function automatic logic [12:0] mk(input logic st, input logic ste, input logic fd, input logic fe,
                                       input logic fm, input logic [1:0] ae, input logic [1:0] be,
                                       input logic ad, input logic bd, input logic bz);
        return {st, st, ste, fd, fe, fm, ae, be, ad, bd, bz};
    endfunction

    exp_t        mon_e;
    logic [12:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_act = {stallF, stallD, stallE, flushD, flushE, flushM,
                       forwardAE, forwardBE, forwardAD, forwardBD, mduBusy};
            nvec++;
            if (mon_act !== mon_e.exp) begin
                nerr++;
                $display("FAIL %s: got %b expected %b", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    task automatic clr_in();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeRegE = 0; writeRegM = 0; writeRegW = 0;
        regWriteE = 0; regWriteM = 0; regWriteW = 0;
        memToRegE = 0; memToRegM = 0;
        branchD = 0; pcSrcD = 0; mduStartE = 0;
    endtask

    // Inputs are set just after a posedge; the monitor samples at the following negedge.
    task automatic chk(input string nm, input logic [12:0] ex);
        sb.push_back('{nm, ex});
        @(posedge clk);
        #1;
    endtask

    localparam logic [12:0] Z = 13'd0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        clr_in();
        @(posedge clk); #1;

        // Reset: hazards present but controls forced low; forwarding still live
        regWriteM = 1; writeRegM = 3; rsE = 3; memToRegE = 1; rtE = 4; rsD = 4; mduStartE = 1;
        chk("rst_forced_zero", mk(0,0,0,0,0,2'b10,2'b00,0,0,0));
        clr_in();
        chk("rst_idle", Z);
        rst = 1'b1;
        chk("post_rst_idle", Z);

        // EX forwarding priority
        regWriteM = 1; writeRegM = 9; regWriteW = 1; writeRegW = 9; rsE = 9;
        chk("fwdAE_M", mk(0,0,0,0,0,2'b10,2'b00,0,0,0));
        writeRegM = 0;
        chk("fwdAE_W", mk(0,0,0,0,0,2'b01,2'b00,0,0,0));
        writeRegW = 0;
        chk("fwdAE_none", Z);
        clr_in();
        regWriteM = 1; writeRegM = 7; regWriteW = 1; writeRegW = 7; rtE = 7;
        chk("fwdBE_M", mk(0,0,0,0,0,2'b00,2'b10,0,0,0));
        regWriteM = 0;
        chk("fwdBE_Mdisabled", mk(0,0,0,0,0,2'b00,2'b01,0,0,0));

        // Decode-stage forwarding, and r0 never forwards
        clr_in();
        regWriteM = 1; writeRegM = 5; rsD = 5; rtD = 6;
        chk("fwdAD", mk(0,0,0,0,0,2'b00,2'b00,1,0,0));
        rsD = 0; rtD = 5;
        chk("fwdBD", mk(0,0,0,0,0,2'b00,2'b00,0,1,0));
        clr_in();
        regWriteM = 1; regWriteW = 1;
        chk("fwd_r0", Z);

        // Load-use
        clr_in();
        memToRegE = 1; rtE = 8; rsD = 8;
        chk("lw_rs", mk(1,0,0,1,0,2'b00,2'b00,0,0,0));
        memToRegE = 0;
        chk("lw_clear", Z);
        memToRegE = 1; rtE = 12; rsD = 0; rtD = 12;
        chk("lw_rt", mk(1,0,0,1,0,2'b00,2'b00,0,0,0));
        rsD = 3; rtD = 4;
        chk("lw_nomatch", Z);

        // Branch compare hazards and redirect
        clr_in();
        branchD = 1; regWriteE = 1; writeRegE = 10; rsD = 10;
        chk("br_exdep", mk(1,0,0,1,0,2'b00,2'b00,0,0,0));
        pcSrcD = 1;
        chk("br_taken_stalled", mk(1,0,0,1,0,2'b00,2'b00,0,0,0));
        regWriteE = 0;
        chk("br_taken_free", mk(0,0,1,0,0,2'b00,2'b00,0,0,0));
        clr_in();
        branchD = 1; memToRegM = 1; writeRegM = 11; rtD = 11;
        chk("br_memdep", mk(1,0,0,1,0,2'b00,2'b00,0,0,0));

        // MDU with a pending redirect; a load-use during BUSY must not flush EX
        clr_in();
        mduStartE = 1; pcSrcD = 1;
        chk("mdu_launch", mk(1,1,0,0,1,2'b00,2'b00,0,0,0));
        memToRegE = 1; rtE = 8; rsD = 8;
        chk("mdu_busy1_lw", mk(1,1,0,0,1,2'b00,2'b00,0,0,1));
        memToRegE = 0; rtE = 0; rsD = 0;
        chk("mdu_busy2", mk(1,1,0,0,1,2'b00,2'b00,0,0,1));
        chk("mdu_done_redirect", mk(0,0,1,0,0,2'b00,2'b00,0,0,0));
        clr_in();
        chk("mdu_no_retrigger", Z);

        // Reset while BUSY at cnt=1
        mduStartE = 1;
        chk("rmdu_launch", mk(1,1,0,0,1,2'b00,2'b00,0,0,0));
        mduStartE = 0;
        chk("rmdu_busy_ignore_start", mk(1,1,0,0,1,2'b00,2'b00,0,0,1));
        rst = 1'b0;
        chk("rmdu_reset_low", Z);
        rst = 1'b1;
        chk("rmdu_after_release", Z);

        // Short reset pulse between edges must clear state without a clock edge
        mduStartE = 1;
        chk("pulse_launch", mk(1,1,0,0,1,2'b00,2'b00,0,0,0));
        mduStartE = 0;
        rst = 1'b0; #2; rst = 1'b1;
        chk("pulse_async_clear", Z);

        // Counter scenario: fresh reset, one MDU op (3 stalls) then one load-use
        rst = 1'b0;
        chk("perf_rst", Z);
        rst = 1'b1;
        mduStartE = 1;
        chk("perf_mdu0", mk(1,1,0,0,1,2'b00,2'b00,0,0,0));
        chk("perf_mdu1", mk(1,1,0,0,1,2'b00,2'b00,0,0,1));
        chk("perf_mdu2", mk(1,1,0,0,1,2'b00,2'b00,0,0,1));
        chk("perf_mdu_done", Z);
        clr_in();
        memToRegE = 1; rtE = 8; rsD = 8;
        chk("perf_lw", mk(1,0,0,1,0,2'b00,2'b00,0,0,0));
        clr_in();
        chk("perf_idle", Z);
`ifdef HAZARD_PERF_EN
        nvec++;
        if (stallCycles !== 32'd4) begin
            nerr++;
            $display("FAIL perf_stallCycles: got %0d expected 4", stallCycles);
        end
        nvec++;
        if (flushCount !== 32'd1) begin
            nerr++;
            $display("FAIL perf_flushCount: got %0d expected 1", flushCount);
        end
`endif

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
